// File: rtl/apb_qspi_burst_bridge_if.sv
// APB bus bundle between the QSPI bridge and its completer.
// Requester drives the request side, completer the response side.
interface apb_qspi_burst_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 24
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  pclk;
  logic                  preset_n;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [LANES-1:0]      pstrb;
  logic [2:0]            pprot;
  logic                  pwakeup;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport requester (
    output pclk, preset_n, paddr, psel,
    output penable, pwrite, pwdata, pstrb,
    output pprot, pwakeup,
    input  prdata, pready, pslverr
  );

  modport completer (
    input  pclk, preset_n, paddr, psel,
    input  penable, pwrite, pwdata, pstrb,
    input  pprot, pwakeup,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_qspi_burst_bridge.sv
// QSPI byte stream to APB word bridge with byte-strobe writes.
// Optional access timeout: define APB_BRIDGE_TIMEOUT_EN.
module apb_qspi_burst_bridge #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 24,
  parameter logic [7:0]  OP_READ        = 8'h40,
  parameter logic [7:0]  OP_WRITE       = 8'h41,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        insn_valid,
  input  logic [7:0]  opcode,
  input  logic [23:0] addr,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        rd_mode,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        status_clear,
  output logic        err_sticky,
  output logic        overrun,
  apb_qspi_burst_bridge_if.requester apb
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(LANES);
  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [1:0] M_NONE = 2'd0;
  localparam logic [1:0] M_RD   = 2'd1;
  localparam logic [1:0] M_WR   = 2'd2;

  if (!(DATA_WIDTH == 16 || DATA_WIDTH == 32 ||
        DATA_WIDTH == 64) || ADDR_WIDTH > 24 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_qspi_burst_bridge: bad parameters");
  end

  logic [1:0]       state;
  logic [1:0]       mode;
  logic [AW-1:0]    ptr;
  logic [LB-1:0]    lane;
  logic [AW-1:0]    word_addr;
  logic [DW-1:0]    fill;
  logic [LANES-1:0] strb;
  logic [DW-1:0]    fill_n;
  logic [LANES-1:0] strb_n;
  logic             stage_valid;
  logic [DW-1:0]    stage_data;
  logic [LANES-1:0] stage_strb;
  logic [AW-1:0]    stage_addr;
  logic             rd_pend;
  logic             rd_iss;
  logic [LB-1:0]    rd_lane;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rbuf;
  logic             rbuf_valid;
  logic [DW-1:0]    rd_word;

  logic wr_try;
  logic full_hand;
  logic stop_hand;
  logic hand;
  logic blocked;
  logic do_hand;
  logic wr_acc;
  logic rd_req;
  logic rd_hit;
  logic rd_miss;
  logic in_access;
  logic tmo;
  logic acc_done;
  logic wr_done;
  logic rd_done;
  logic issue_wr;
  logic issue_rd;
  logic err_set;

  assign lane      = ptr[LB-1:0];
  assign word_addr = {ptr[AW-1:LB], {LB{1'b0}}};
  assign rd_mode   = (mode == M_RD);

  assign wr_try    = wr_valid && (mode == M_WR);
  assign full_hand = wr_try && (lane == {LB{1'b1}});
  assign stop_hand = stop && (mode == M_WR) && (|strb_n);
  assign hand      = full_hand || stop_hand;
  assign blocked   = hand && stage_valid;
  assign do_hand   = hand && !stage_valid;
  assign wr_acc    = wr_try && !blocked;

  assign rd_req  = rd_ready && (mode == M_RD) && !rd_pend;
  assign rd_hit  = rd_req && rbuf_valid && (lane != '0);
  assign rd_miss = rd_req && !rd_hit;

  assign in_access = (state == S_ACCESS);
  assign acc_done  = in_access && (apb.pready || tmo);
  assign wr_done   = acc_done && apb.pwrite;
  assign rd_done   = acc_done && !apb.pwrite;
  assign issue_wr  = (state == S_IDLE) && stage_valid;
  assign issue_rd  = (state == S_IDLE) && !stage_valid &&
                     rd_pend && !rd_iss;
  assign rd_word   = tmo ? '1 : apb.prdata;
  assign err_set   = (acc_done && apb.pready && apb.pslverr) || tmo;

  assign apb.pclk     = clk;
  assign apb.preset_n = rst_n;
  assign apb.pprot    = 3'b000;
  assign apb.pwakeup  = 1'b0;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt;

  assign tmo = in_access && !apb.pready &&
               (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting in ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          tcnt <= '0;
    else if (!in_access) tcnt <= '0;
    else                 tcnt <= tcnt + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  // Merge the incoming byte into the fill word
  always_comb begin
    fill_n = fill;
    strb_n = strb;
    if (wr_try) begin
      fill_n[{lane, 3'b000} +: 8] = wr_data;
      strb_n[lane] = 1'b1;
    end
  end

  // Framing, byte pointer and fill register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= M_NONE;
      ptr  <= '0;
      fill <= '0;
      strb <= '0;
    end else begin
      if (insn_valid) begin
        ptr <= addr[AW-1:0];
        if (opcode == OP_READ)       mode <= M_RD;
        else if (opcode == OP_WRITE) mode <= M_WR;
        else                         mode <= M_NONE;
      end else begin
        if (start) mode <= M_NONE;
        if (wr_acc || rd_req) ptr <= ptr + 1'b1;
      end
      if (start || do_hand) begin
        fill <= '0;
        strb <= '0;
      end else if (wr_acc) begin
        fill <= fill_n;
        strb <= strb_n;
      end
    end
  end

  // Single-entry write staging register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      stage_strb  <= '0;
      stage_addr  <= '0;
    end else if (do_hand) begin
      stage_valid <= 1'b1;
      stage_data  <= fill_n;
      stage_strb  <= strb_n;
      stage_addr  <= word_addr;
    end else if (wr_done) begin
      stage_valid <= 1'b0;
    end
  end

  // Read requests, word buffer and byte return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend    <= 1'b0;
      rd_iss     <= 1'b0;
      rd_lane    <= '0;
      rd_addr    <= '0;
      rbuf       <= '0;
      rbuf_valid <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (insn_valid || start) rbuf_valid <= 1'b0;
      if (rd_hit) begin
        rd_valid <= 1'b1;
        rd_data  <= rbuf[{lane, 3'b000} +: 8];
      end
      if (rd_miss) begin
        rd_pend <= 1'b1;
        rd_lane <= lane;
        rd_addr <= word_addr;
      end
      if (issue_rd) rd_iss <= 1'b1;
      if (rd_done) begin
        rd_pend    <= 1'b0;
        rd_iss     <= 1'b0;
        rbuf       <= rd_word;
        rbuf_valid <= 1'b1;
        rd_valid   <= 1'b1;
        rd_data    <= rd_word[{rd_lane, 3'b000} +: 8];
      end
    end
  end

  // APB requester state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      apb.pstrb   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (issue_wr) begin
            state      <= S_SETUP;
            apb.psel   <= 1'b1;
            apb.pwrite <= 1'b1;
            apb.paddr  <= stage_addr;
            apb.pwdata <= stage_data;
            apb.pstrb  <= stage_strb;
          end else if (issue_rd) begin
            state      <= S_SETUP;
            apb.psel   <= 1'b1;
            apb.pwrite <= 1'b0;
            apb.paddr  <= rd_addr;
            apb.pwdata <= '0;
            apb.pstrb  <= '0;
          end
        end
        S_SETUP: begin
          state       <= S_ACCESS;
          apb.penable <= 1'b1;
        end
        S_ACCESS: begin
          if (acc_done) begin
            state       <= S_IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
          end
        end
        default: begin
          state       <= S_IDLE;
          apb.psel    <= 1'b0;
          apb.penable <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status; a same-cycle set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      err_sticky <= err_set || (err_sticky && !status_clear);
      overrun    <= blocked || (overrun && !status_clear);
    end
  end
endmodule

// File: tb/tb_apb_qspi_burst_bridge.sv
// Directed scoreboard bench for apb_qspi_burst_bridge.
// Define APB_BRIDGE_TIMEOUT_EN to also run the timeout step.
module tb_apb_qspi_burst_bridge;
  typedef struct packed {
    logic [23:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        insn_valid = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [23:0] addr = 24'h0;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        rd_mode;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        status_clear = 1'b0;
  logic        err_sticky;
  logic        overrun;

  int   total = 0;
  int   bad = 0;
  bit   hold = 1'b0;
  bit   seen = 1'b0;
  int   acc_cycles = 0;
  txn_t exp_apb[$];
  logic [32:0] resp_q[$];
  logic [7:0]  exp_rd[$];

  apb_qspi_burst_bridge_if #(
    .DATA_WIDTH(32), .ADDR_WIDTH(24)
  ) apb ();

  apb_qspi_burst_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(24),
    .OP_READ(8'h40), .OP_WRITE(8'h41),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .stop(stop),
    .insn_valid(insn_valid), .opcode(opcode),
    .addr(addr), .wr_valid(wr_valid),
    .wr_data(wr_data), .rd_mode(rd_mode),
    .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .status_clear(status_clear),
    .err_sticky(err_sticky), .overrun(overrun),
    .apb(apb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // APB completer model and request scoreboard
  always @(negedge clk) begin
    txn_t e;
    logic [32:0] r;
    if (apb.psel && apb.penable) begin
      acc_cycles++;
      if (!seen) begin
        seen = 1'b1;
        total++;
        assert (exp_apb.size() > 0) else begin
          bad++;
          $error("FAIL apb_extra observed=%0h expected=none",
                 apb.paddr);
        end
        if (exp_apb.size() > 0) begin
          e = exp_apb.pop_front();
          check("paddr", 64'(apb.paddr), 64'(e.a));
          check("pwrite", 64'(apb.pwrite), 64'(e.w));
          if (e.w) begin
            check("pwdata", 64'(apb.pwdata), 64'(e.d));
            check("pstrb", 64'(apb.pstrb), 64'(e.s));
          end
        end
        r = (resp_q.size() > 0 && !apb.pwrite) ?
            resp_q.pop_front() : 33'h0;
        apb.prdata  = r[31:0];
        apb.pslverr = r[32];
      end
      apb.pready = !hold;
    end else begin
      seen        = 1'b0;
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      apb.prdata  = 32'h0;
      if (apb.psel) acc_cycles = 0;
    end
  end

  // Read byte scoreboard
  always @(negedge clk) begin
    logic [7:0] eb;
    if (rd_valid) begin
      total++;
      assert (exp_rd.size() > 0) else begin
        bad++;
        $error("FAIL rd_extra observed=%0h expected=none",
               rd_data);
      end
      if (exp_rd.size() > 0) begin
        eb = exp_rd.pop_front();
        check("rd_data", 64'(rd_data), 64'(eb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] op,
                       input logic [23:0] a);
    start = 1'b1;
    tick();
    start = 1'b0;
    insn_valid = 1'b1;
    opcode = op;
    addr = a;
    tick();
    insn_valid = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b,
                         input bit with_stop);
    wr_valid = 1'b1;
    wr_data = b;
    stop = with_stop;
    tick();
    wr_valid = 1'b0;
    stop = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic rd_byte(input logic [7:0] eb,
                         input bit hit);
    int n;
    exp_rd.push_back(eb);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    n = 1;
    while (!rd_valid && n < 60) begin
      tick();
      n++;
    end
    if (hit) check("rd_latency", 64'(n), 64'd1);
    else     check("rd_seen", 64'(rd_valid), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_apb.size() != 0 || apb.psel) && n < 200) begin
      tick();
      n++;
    end
    check("apb_drain", 64'(exp_apb.size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic clear_status();
    status_clear = 1'b1;
    tick();
    status_clear = 1'b0;
  endtask

  initial begin
    int n;
    tick();
    tick();
    check("rst_psel", 64'(apb.psel), 64'd0);
    check("rst_penable", 64'(apb.penable), 64'd0);
    check("rst_paddr", 64'(apb.paddr), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_mode", 64'(rd_mode), 64'd0);
    check("rst_err", 64'(err_sticky), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    tick();

    // full word write
    exp_apb.push_back('{24'h001000, 1'b1, 32'hDDCCBBAA, 4'hF});
    frame(8'h41, 24'h001000);
    check("wr_mode_rd", 64'(rd_mode), 64'd0);
    wr_byte(8'hAA, 1'b0);
    wr_byte(8'hBB, 1'b0);
    wr_byte(8'hCC, 1'b0);
    wr_byte(8'hDD, 1'b0);
    do_stop();
    wait_idle();

    // partial word flushed by stop
    exp_apb.push_back('{24'h001000, 1'b1, 32'h00221100, 4'h6});
    frame(8'h41, 24'h001001);
    wr_byte(8'h11, 1'b0);
    wr_byte(8'h22, 1'b0);
    do_stop();
    wait_idle();

    // stop in the same cycle as the last byte
    exp_apb.push_back('{24'h003000, 1'b1, 32'h66550000, 4'hC});
    frame(8'h41, 24'h003002);
    wr_byte(8'h55, 1'b0);
    wr_byte(8'h66, 1'b1);
    wait_idle();

    // two-word read burst
    exp_apb.push_back('{24'h002000, 1'b0, 32'h0, 4'h0});
    exp_apb.push_back('{24'h002004, 1'b0, 32'h0, 4'h0});
    resp_q.push_back({1'b0, 32'h44332211});
    resp_q.push_back({1'b0, 32'h88776655});
    frame(8'h40, 24'h002000);
    check("rd_mode", 64'(rd_mode), 64'd1);
    rd_byte(8'h11, 1'b0);
    rd_byte(8'h22, 1'b1);
    rd_byte(8'h33, 1'b1);
    rd_byte(8'h44, 1'b1);
    rd_byte(8'h55, 1'b0);
    rd_byte(8'h66, 1'b1);
    rd_byte(8'h77, 1'b1);
    rd_byte(8'h88, 1'b1);
    do_stop();
    wait_idle();
    check("rd_no_err", 64'(err_sticky), 64'd0);

    // slave error on a read
    exp_apb.push_back('{24'h004000, 1'b0, 32'h0, 4'h0});
    resp_q.push_back({1'b1, 32'hA1B2C3D4});
    frame(8'h40, 24'h004000);
    rd_byte(8'hD4, 1'b0);
    check("err_set", 64'(err_sticky), 64'd1);
    do_stop();
    clear_status();
    check("err_clear", 64'(err_sticky), 64'd0);

    // overrun while the staging register is busy
    hold = 1'b1;
    exp_apb.push_back('{24'h005000, 1'b1, 32'h04030201, 4'hF});
    exp_apb.push_back('{24'h005004, 1'b1, 32'h09070605, 4'hF});
    frame(8'h41, 24'h005000);
    wr_byte(8'h01, 1'b0);
    wr_byte(8'h02, 1'b0);
    wr_byte(8'h03, 1'b0);
    wr_byte(8'h04, 1'b0);
    wr_byte(8'h05, 1'b0);
    wr_byte(8'h06, 1'b0);
    wr_byte(8'h07, 1'b0);
    wr_byte(8'h08, 1'b0);
    check("overrun_set", 64'(overrun), 64'd1);
    hold = 1'b0;
    n = 0;
    while (apb.psel && n < 20) begin
      tick();
      n++;
    end
    wr_byte(8'h09, 1'b0);
    do_stop();
    wait_idle();
    clear_status();
    check("overrun_clear", 64'(overrun), 64'd0);

`ifdef APB_BRIDGE_TIMEOUT_EN
    // read that never gets pready
    hold = 1'b1;
    exp_apb.push_back('{24'h008000, 1'b0, 32'h0, 4'h0});
    resp_q.push_back({1'b0, 32'h12345678});
    frame(8'h40, 24'h008000);
    rd_byte(8'hFF, 1'b0);
    check("tmo_cycles", 64'(acc_cycles), 64'd16);
    check("tmo_err", 64'(err_sticky), 64'd1);
    check("tmo_idle", 64'(apb.psel), 64'd0);
    hold = 1'b0;
    do_stop();
    clear_status();
`endif

    // reset in the middle of an access
    hold = 1'b1;
    exp_apb.push_back('{24'h006000, 1'b1, 32'hF3F2F1F0, 4'hF});
    frame(8'h41, 24'h006000);
    wr_byte(8'hF0, 1'b0);
    wr_byte(8'hF1, 1'b0);
    wr_byte(8'hF2, 1'b0);
    wr_byte(8'hF3, 1'b0);
    n = 0;
    while (!(apb.psel && apb.penable) && n < 20) begin
      tick();
      n++;
    end
    check("rst_reach_access", 64'(apb.penable), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_psel", 64'(apb.psel), 64'd0);
    check("rst_mid_penable", 64'(apb.penable), 64'd0);
    hold = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    exp_apb.push_back('{24'h007000, 1'b1, 32'h3C2B1A09, 4'hF});
    frame(8'h41, 24'h007000);
    wr_byte(8'h09, 1'b0);
    wr_byte(8'h1A, 1'b0);
    wr_byte(8'h2B, 1'b0);
    wr_byte(8'h3C, 1'b0);
    do_stop();
    wait_idle();
    check("end_rd_left", 64'(exp_rd.size()), 64'd0);
    check("end_err", 64'(err_sticky), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
